// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-in-first-out buffer with a registered read
//             port and full/empty status flags. Depth may be any positive
//             integer; pointers wrap by explicit compare, not by truncation.
//  Ports    : clk      - clock, all state updates on the rising edge
//             reset    - synchronous, active-high reset
//             data_in  - write data, captured when a push is accepted
//             push     - write request (level-sensitive, one op per edge)
//             pop      - read request  (level-sensitive, one op per edge)
//             data_out - registered read data, holds last popped word
//             empty    - FIFO holds zero entries
//             full     - FIFO holds FIFO_DEPTH entries
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int FIFO_DEPTH = 5,
  parameter int FIFO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  // A depth of 1 still needs a one-bit pointer to index the array.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [FIFO_WIDTH-1:0] r_data_out;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  // Flags come only from the registered occupancy count.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_CNT);

  // A push while full is still accepted when a pop frees a slot on the same
  // edge. A pop while empty is ignored, so push+pop on empty never falls
  // through to data_out.
  assign w_push_ok = push & (~w_full | pop);
  assign w_pop_ok  = pop  & ~w_empty;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  // Storage array: not cleared on reset, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= w_rd_ptr_nxt;
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign empty    = w_empty;
  assign full     = w_full;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo
//  Purpose  : Self-checking bench for sync_fifo. The driver applies directed
//             and random push/pop/reset patterns, advances a queue-based
//             reference model and records the expected outputs; a monitor
//             compares them against the DUT after every rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;

  sync_fifo #(
    .FIFO_DEPTH(DEPTH),
    .FIFO_WIDTH(WIDTH)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .push     (push),
    .pop      (pop),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: contents as a plain queue plus the last word read.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout;

  int tests;
  int fails;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // One clock of stimulus: drive inputs after the falling edge, advance the
  // model for the coming rising edge and queue what the DUT should show.
  task automatic step(input logic r, input logic p, input logic q, input logic [WIDTH-1:0] d);
    bit was_full;
    bit was_empty;
    exp_t e;
    @(negedge clk);
    reset   = r;
    push    = p;
    pop     = q;
    data_in = d;
    if (r) begin
      m_q.delete();
      m_dout = '0;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if (q && !was_empty) m_dout = m_q.pop_front();
      if (p && (!was_full || q)) m_q.push_back(d);
    end
    e.dout  = m_dout;
    e.empty = (m_q.size() == 0);
    e.full  = (m_q.size() == DEPTH);
    exp_q.push_back(e);
  endtask

  // Monitor: checks one queued expectation after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_out", 32'(data_out), 32'(e.dout));
      chk("empty",    32'(empty),    32'(e.empty));
      chk("full",     32'(full),     32'(e.full));
    end
  end

  initial begin
    logic [WIDTH-1:0] fill_vals [5];
    tests   = 0;
    fails   = 0;
    m_dout  = '0;
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    fill_vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    // Reset
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h5A);   // reset wins over push/pop

    // Fill, then a dropped push while full
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, fill_vals[i]);
    step(1'b0, 1'b1, 1'b0, 8'h11);

    // Drain, then an extra pop on empty
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Wrap-around
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // Push+pop on empty, then fill and push+pop on full
    step(1'b0, 1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b0, 1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // Reset with three entries stored, then push/pop
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h6B);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Random traffic with varying push/pop bias and rare resets
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 250) % 3;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2))),
           ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2))),
           8'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
